// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: defaults, state encoding
// and a saturating-increment helper used by the statistics counters.
package fetch_ctrl_pkg;

   localparam int PC_WIDTH_DEF  = 16;
   localparam int INSTR_WIDTH   = 32;
   localparam int RESET_VEC_DEF = 0;
   localparam int MAX_STALL_DEF = 15;
   localparam int STATS_WIDTH   = 16;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_RUN   = 3'd1,
      ST_REDIR = 3'd2,
      ST_STALL = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
      return (value == {STATS_WIDTH{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/fetch_ctrl_stats.sv
// Saturating redirect / stall-cycle counters for the fetch controller.
// Only instantiated when FETCH_CTRL_STATS_EN is defined.
module fetch_ctrl_stats
   import fetch_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redir_evt,
   input  logic                   stall_evt,
   output logic [STATS_WIDTH-1:0] redir_cnt,
   output logic [STATS_WIDTH-1:0] stall_cnt
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redir_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (redir_evt) redir_cnt <= sat_inc(redir_cnt);
         if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: arbitrates branch/jump redirects, load-use
// stalls and end-of-program parking. Optional statistics via FETCH_CTRL_STATS_EN.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VEC = PC_WIDTH'(RESET_VEC_DEF),
   parameter int                  MAX_STALL = MAX_STALL_DEF
) (
   input  logic                clk_in,
   input  logic                RST,
   input  logic                br_req,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                jmp_req,
   input  logic [PC_WIDTH-1:0] jmp_target,
   input  logic                hz_stall,
   input  logic                if_done,
   output logic                pc_chg,
   output logic [PC_WIDTH-1:0] pc_in,
   output logic                if_en,
   output logic                flush_if,
   output logic                flush_id,
   output logic                bubble,
   output logic                halted,
   output logic                stall_err
`ifdef FETCH_CTRL_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0] redir_cnt,
   output logic [STATS_WIDTH-1:0] stall_cnt
`endif
);

   localparam int             CW       = $clog2(MAX_STALL + 2);
   localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_STALL);
   localparam logic [CW-1:0]  HOLD_SAT = CW'(MAX_STALL + 1);

   state_t               state, state_nxt;
   logic [CW-1:0]        hold_cnt, hold_nxt;
   logic                 pc_chg_nxt, if_en_nxt, flush_if_nxt, flush_id_nxt;
   logic                 bubble_nxt, halted_nxt, err_nxt;
   logic [PC_WIDTH-1:0]  pc_in_nxt;

   always_ff @(posedge clk_in) begin
      if (!RST) begin
         state     <= ST_BOOT;
         hold_cnt  <= '0;
         pc_chg    <= 1'b0;
         pc_in     <= '0;
         if_en     <= 1'b0;
         flush_if  <= 1'b0;
         flush_id  <= 1'b0;
         bubble    <= 1'b0;
         halted    <= 1'b0;
         stall_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         pc_chg    <= pc_chg_nxt;
         pc_in     <= pc_in_nxt;
         if_en     <= if_en_nxt;
         flush_if  <= flush_if_nxt;
         flush_id  <= flush_id_nxt;
         bubble    <= bubble_nxt;
         halted    <= halted_nxt;
         stall_err <= err_nxt;
      end
   end

   // A taken branch outranks everything except the boot load and the redirect shadow.
   always_comb begin
      state_nxt    = state;
      hold_nxt     = '0;
      pc_chg_nxt   = 1'b0;
      pc_in_nxt    = pc_in;
      if_en_nxt    = 1'b0;
      flush_if_nxt = 1'b0;
      flush_id_nxt = 1'b0;
      bubble_nxt   = 1'b0;
      halted_nxt   = 1'b0;
      err_nxt      = stall_err;

      case (state)
         ST_BOOT: begin
            pc_chg_nxt = 1'b1;
            pc_in_nxt  = RESET_VEC;
            if_en_nxt  = 1'b1;
            state_nxt  = ST_RUN;
         end
         ST_RUN: begin
            if (br_req) begin
               pc_chg_nxt   = 1'b1;
               pc_in_nxt    = br_target;
               flush_if_nxt = 1'b1;
               flush_id_nxt = 1'b1;
               if_en_nxt    = 1'b1;
               state_nxt    = ST_REDIR;
            end else if (jmp_req) begin
               pc_chg_nxt   = 1'b1;
               pc_in_nxt    = jmp_target;
               flush_if_nxt = 1'b1;
               if_en_nxt    = 1'b1;
               state_nxt    = ST_REDIR;
            end else if (hz_stall) begin
               bubble_nxt = 1'b1;
               hold_nxt   = CW'(1);
               state_nxt  = ST_STALL;
            end else if (if_done) begin
               halted_nxt = 1'b1;
               state_nxt  = ST_HALT;
            end else begin
               if_en_nxt = 1'b1;
            end
         end
         ST_REDIR: begin
            if_en_nxt = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_STALL: begin
            if (br_req) begin
               pc_chg_nxt   = 1'b1;
               pc_in_nxt    = br_target;
               flush_if_nxt = 1'b1;
               flush_id_nxt = 1'b1;
               if_en_nxt    = 1'b1;
               state_nxt    = ST_REDIR;
            end else if (hz_stall) begin
               bubble_nxt = 1'b1;
               hold_nxt   = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
            end else begin
               if_en_nxt = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_HALT: begin
            if (br_req) begin
               pc_chg_nxt   = 1'b1;
               pc_in_nxt    = br_target;
               flush_if_nxt = 1'b1;
               flush_id_nxt = 1'b1;
               if_en_nxt    = 1'b1;
               state_nxt    = ST_REDIR;
            end else begin
               halted_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_BOOT;
      endcase

      if (hold_nxt > HOLD_MAX) err_nxt = 1'b1;
   end

`ifdef FETCH_CTRL_STATS_EN
   // The pc_chg that follows BOOT lands in RUN, so REDIR marks exactly the real redirects.
   fetch_ctrl_stats u_stats (
      .clk       (clk_in),
      .rst_n     (RST),
      .redir_evt (pc_chg && (state == ST_REDIR)),
      .stall_evt (bubble),
      .redir_cnt (redir_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios plus $urandom traffic, checked
// against a priority-rule reference model. Stats ports checked when FETCH_CTRL_STATS_EN is set.
module tb_fetch_ctrl;

   localparam int          MAXS  = 15;
   localparam logic [15:0] RVEC  = 16'h0000;

   typedef struct packed {
      logic        pc_chg;
      logic [15:0] pc_in;
      logic        if_en;
      logic        flush_if;
      logic        flush_id;
      logic        bubble;
      logic        halted;
      logic        stall_err;
      logic [15:0] rcnt;
      logic [15:0] scnt;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        RST = 1'b0;
   logic        br_req = 1'b0, jmp_req = 1'b0, hz_stall = 1'b0, if_done = 1'b0;
   logic [15:0] br_target = '0, jmp_target = '0;
   logic        pc_chg, if_en, flush_if, flush_id, bubble, halted, stall_err;
   logic [15:0] pc_in;
`ifdef FETCH_CTRL_STATS_EN
   logic [15:0] redir_cnt, stall_cnt;
`endif

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;

   bit          m_boot = 1'b1, m_shadow = 1'b0, m_halt = 1'b0, m_err = 1'b0;
   int          m_stall_len = 0;
   logic [15:0] m_pc = '0, m_rcnt = '0, m_scnt = '0;

   always #5 clk_in = ~clk_in;

   fetch_ctrl dut (
      .clk_in     (clk_in),
      .RST        (RST),
      .br_req     (br_req),
      .br_target  (br_target),
      .jmp_req    (jmp_req),
      .jmp_target (jmp_target),
      .hz_stall   (hz_stall),
      .if_done    (if_done),
      .pc_chg     (pc_chg),
      .pc_in      (pc_in),
      .if_en      (if_en),
      .flush_if   (flush_if),
      .flush_id   (flush_id),
      .bubble     (bubble),
      .halted     (halted),
      .stall_err  (stall_err)
`ifdef FETCH_CTRL_STATS_EN
      ,
      .redir_cnt  (redir_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   // Drive one cycle of inputs and predict the registered response for the next cycle.
   task automatic applyStimulus(input logic r, input logic b, input logic [15:0] bt,
                                input logic j, input logic [15:0] jt,
                                input logic hz, input logic d);
      exp_t e;
      bit   redir;
      @(negedge clk_in);
      RST = r; br_req = b; br_target = bt; jmp_req = j; jmp_target = jt;
      hz_stall = hz; if_done = d;
      e = '0;
      redir = 1'b0;
      if (!r) begin
         m_boot = 1'b1; m_shadow = 1'b0; m_halt = 1'b0; m_err = 1'b0;
         m_stall_len = 0; m_pc = '0; m_rcnt = '0; m_scnt = '0;
      end else if (m_boot) begin
         m_boot = 1'b0; m_pc = RVEC; e.pc_chg = 1'b1; e.if_en = 1'b1;
      end else if (m_shadow) begin
         m_shadow = 1'b0; e.if_en = 1'b1;
      end else if (b) begin
         m_pc = bt; e.pc_chg = 1'b1; e.flush_if = 1'b1; e.flush_id = 1'b1; e.if_en = 1'b1;
         m_shadow = 1'b1; m_halt = 1'b0; m_stall_len = 0; redir = 1'b1;
      end else if (m_halt) begin
         e.halted = 1'b1;
      end else if (m_stall_len > 0) begin
         if (hz) begin
            m_stall_len = (m_stall_len > MAXS) ? MAXS + 1 : m_stall_len + 1;
            e.bubble = 1'b1;
         end else begin
            m_stall_len = 0; e.if_en = 1'b1;
         end
      end else if (j) begin
         m_pc = jt; e.pc_chg = 1'b1; e.flush_if = 1'b1; e.if_en = 1'b1;
         m_shadow = 1'b1; redir = 1'b1;
      end else if (hz) begin
         m_stall_len = 1; e.bubble = 1'b1;
      end else if (d) begin
         m_halt = 1'b1; e.halted = 1'b1;
      end else begin
         e.if_en = 1'b1;
      end
      if (m_stall_len > MAXS) m_err = 1'b1;
      e.stall_err = m_err;
      e.pc_in = m_pc;
      e.rcnt = m_rcnt;
      e.scnt = m_scnt;
      if (r) begin
         if (redir && m_rcnt != 16'hFFFF) m_rcnt = m_rcnt + 16'd1;
         if (e.bubble && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      end
      sb_q.push_back(e);
   endtask

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp("pc_chg",    16'(pc_chg),    16'(e.pc_chg));
      cmp("pc_in",     pc_in,          e.pc_in);
      cmp("if_en",     16'(if_en),     16'(e.if_en));
      cmp("flush_if",  16'(flush_if),  16'(e.flush_if));
      cmp("flush_id",  16'(flush_id),  16'(e.flush_id));
      cmp("bubble",    16'(bubble),    16'(e.bubble));
      cmp("halted",    16'(halted),    16'(e.halted));
      cmp("stall_err", 16'(stall_err), 16'(e.stall_err));
`ifdef FETCH_CTRL_STATS_EN
      cmp("redir_cnt", redir_cnt, e.rcnt);
      cmp("stall_cnt", stall_cnt, e.scnt);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic stallFor(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
   endtask

   // Monitor: every cycle carries a registered response, so one scoreboard entry is consumed per edge.
   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] fetch_ctrl scoreboard bench starting");
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3);

      applyStimulus(1'b1, 1'b1, 16'd20, 1'b1, 16'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'd99, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'd7, 1'b0, 1'b0);
      idle(2);

      stallFor(3);  idle(2);
      stallFor(15); idle(2);
      stallFor(17); idle(2);

      stallFor(2);
      applyStimulus(1'b1, 1'b1, 16'd1, 1'b0, 16'h0, 1'b1, 1'b0);
      idle(2);

      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'd9, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b1, 1'b1, 16'd5, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2);

      stallFor(3);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      idle(4);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(99) >= 2),
                       ($urandom_range(99) < 15), 16'($urandom),
                       ($urandom_range(99) < 15), 16'($urandom),
                       ($urandom_range(99) < 25),
                       ($urandom_range(99) < 5));
      end
      idle(2);

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk_in);
      #2;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
